// File: rtl/clk_period_meter.sv
// Measures the period and high time of a slow, asynchronous signal in clock_in cycles.
// Results leave through a valid/ready port; stalls and dropped results are flagged.
module clk_period_meter #(
  parameter int CNT_W = 28,
  parameter logic [CNT_W-1:0] TIMEOUT = 28'd100_000_000
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             meas_ready,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             sat,
  output logic             stalled,
  output logic             overrun
);

  typedef enum logic {WAIT_EDGE, MEASURE} state_t;

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  state_t           state;
  logic             s_meta;
  logic             s_sync;
  logic             s_prev;
  logic [CNT_W-1:0] per_run;
  logic [CNT_W-1:0] hi_run;
  logic             rise;
  logic             xfer;
  logic             formed;

  assign rise   = s_sync & ~s_prev;
  assign xfer   = meas_valid & meas_ready;
  assign formed = (state == MEASURE) && rise;

  // A result is formed on every rise seen while measuring; the first rise only arms.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      s_meta     <= 1'b0;
      s_sync     <= 1'b0;
      s_prev     <= 1'b0;
      state      <= WAIT_EDGE;
      per_run    <= '0;
      hi_run     <= '0;
      meas_valid <= 1'b0;
      period_cnt <= '0;
      high_cnt   <= '0;
      sat        <= 1'b0;
      stalled    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      s_meta <= sig_in;
      s_sync <= s_meta;
      s_prev <= s_sync;

      case (state)
        WAIT_EDGE: begin
          if (rise) begin
            state   <= MEASURE;
            per_run <= ONE;
            hi_run  <= {{(CNT_W-1){1'b0}}, s_sync};
          end
        end
        MEASURE: begin
          if (rise) begin
            per_run <= ONE;
            hi_run  <= ONE;
          end else begin
            if (per_run != ALL_ONES) per_run <= per_run + ONE;
            if (s_sync && (hi_run != ALL_ONES)) hi_run <= hi_run + ONE;
            if (per_run == (TIMEOUT - ONE)) begin
              stalled <= 1'b1;
              state   <= WAIT_EDGE;
            end
          end
        end
        default: state <= WAIT_EDGE;
      endcase

      // The output slot is reusable when empty or being drained this cycle.
      if (formed) begin
        stalled <= 1'b0;
        if (!meas_valid || xfer) begin
          meas_valid <= 1'b1;
          period_cnt <= per_run;
          high_cnt   <= hi_run;
          sat        <= (per_run == ALL_ONES);
        end else begin
          overrun <= 1'b1;
        end
      end else if (xfer) begin
        meas_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter: two instances (wide/TIMEOUT=64 and 4-bit/TIMEOUT=15)
// checked every cycle against a timestamp-based reference model plus literal expectations.
module tb_clk_period_meter;

  localparam int A_W  = 28;
  localparam int A_TO = 64;
  localparam int B_W  = 4;
  localparam int B_TO = 15;

  logic clock_in = 1'b0;
  logic reset_a, reset_b, sig_a, sig_b, ready_a, ready_b;
  logic valid_a, valid_b, sat_a, sat_b, stalled_a, stalled_b, overrun_a, overrun_b;
  logic [A_W-1:0] period_a, high_a;
  logic [B_W-1:0] period_b, high_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state; index 0 is instance a, index 1 is instance b.
  bit d1[2], d2[2], d3[2];
  bit armed[2];
  int last_rise[2], high_seen[2];
  bit e_valid[2], e_sat[2], e_stall[2], e_ovr[2];
  int e_per[2], e_high[2];

  clk_period_meter #(.CNT_W(A_W), .TIMEOUT(28'd64)) dut_a (
    .clock_in(clock_in), .reset(reset_a), .sig_in(sig_a), .meas_ready(ready_a),
    .meas_valid(valid_a), .period_cnt(period_a), .high_cnt(high_a),
    .sat(sat_a), .stalled(stalled_a), .overrun(overrun_a)
  );

  clk_period_meter #(.CNT_W(B_W), .TIMEOUT(4'd15)) dut_b (
    .clock_in(clock_in), .reset(reset_b), .sig_in(sig_b), .meas_ready(ready_b),
    .meas_valid(valid_b), .period_cnt(period_b), .high_cnt(high_b),
    .sat(sat_b), .stalled(stalled_b), .overrun(overrun_b)
  );

  always #5 clock_in = ~clock_in;

  task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Period is the distance between detected rises; high is the count of high synchronized samples.
  task automatic model_step(input int k, input logic s, input logic r, input logic rdy);
    bit rise, formed, xfer;
    int span, hi, to, cmax;
    formed = 0;
    span   = 0;
    hi     = 0;
    to     = (k == 0) ? A_TO : B_TO;
    cmax   = (k == 0) ? ((1 << A_W) - 1) : ((1 << B_W) - 1);
    if (r) begin
      d1[k] = 0; d2[k] = 0; d3[k] = 0;
      armed[k] = 0; last_rise[k] = 0; high_seen[k] = 0;
      e_valid[k] = 0; e_per[k] = 0; e_high[k] = 0;
      e_sat[k] = 0; e_stall[k] = 0; e_ovr[k] = 0;
    end else begin
      rise = d2[k] && !d3[k];
      if (rise) begin
        if (armed[k]) begin
          formed = 1;
          span   = cyc - last_rise[k];
          hi     = high_seen[k];
        end
        armed[k]     = 1;
        last_rise[k] = cyc;
        high_seen[k] = 1;
      end else if (armed[k]) begin
        if (d2[k]) high_seen[k]++;
        if (cyc - last_rise[k] == to - 1) begin
          e_stall[k] = 1;
          armed[k]   = 0;
        end
      end
      xfer = e_valid[k] && rdy;
      if (formed) begin
        e_stall[k] = 0;
        if (!e_valid[k] || xfer) begin
          e_valid[k] = 1;
          e_per[k]   = (span > cmax) ? cmax : span;
          e_high[k]  = (hi > cmax) ? cmax : hi;
          e_sat[k]   = (span >= cmax);
        end else begin
          e_ovr[k] = 1;
        end
      end else if (xfer) begin
        e_valid[k] = 0;
      end
      d3[k] = d2[k];
      d2[k] = d1[k];
      d1[k] = s;
    end
  endtask

  always @(posedge clock_in) begin
    model_step(0, sig_a, reset_a, ready_a);
    model_step(1, sig_b, reset_b, ready_b);
    cyc++;
  end

  task automatic check_output(input int k, input logic v, input logic [31:0] per,
                              input logic [31:0] hi, input logic st, input logic stl,
                              input logic ov);
    string tag;
    tag = (k == 0) ? "a" : "b";
    check_value({"valid_", tag},   32'(v),   32'(e_valid[k]));
    check_value({"period_", tag},  per,      e_per[k]);
    check_value({"high_", tag},    hi,       e_high[k]);
    check_value({"sat_", tag},     32'(st),  32'(e_sat[k]));
    check_value({"stalled_", tag}, 32'(stl), 32'(e_stall[k]));
    check_value({"overrun_", tag}, 32'(ov),  32'(e_ovr[k]));
  endtask

  always @(negedge clock_in) begin
    check_output(0, valid_a, 32'(period_a), 32'(high_a), sat_a, stalled_a, overrun_a);
    check_output(1, valid_b, 32'(period_b), 32'(high_b), sat_b, stalled_b, overrun_b);
  end

  task automatic apply_stimulus(input int k, input int period, input int high, input int periods);
    for (int p = 0; p < periods; p++) begin
      for (int i = 0; i < period; i++) begin
        @(negedge clock_in);
        if (k == 0) sig_a = (i < high);
        else sig_b = (i < high);
      end
    end
  endtask

  initial begin
    int c;
    reset_a = 1; reset_b = 1; sig_a = 0; sig_b = 0; ready_a = 1; ready_b = 1;
    repeat (3) @(negedge clock_in);
    check_value("lit_reset_valid", 32'(valid_a), 0);
    check_value("lit_reset_period", 32'(period_a), 0);
    check_value("lit_reset_stalled", 32'(stalled_a), 0);
    check_value("lit_reset_overrun", 32'(overrun_b), 0);
    reset_a = 0; reset_b = 0;

    apply_stimulus(0, 4, 2, 10);
    check_value("lit_div4_period", 32'(period_a), 4);
    check_value("lit_div4_high", 32'(high_a), 2);
    check_value("lit_div4_sat", 32'(sat_a), 0);

    apply_stimulus(0, 7, 3, 10);
    check_value("lit_div7_period", 32'(period_a), 7);
    check_value("lit_div7_high", 32'(high_a), 3);

    apply_stimulus(0, 50, 25, 4);
    check_value("lit_div50_period", 32'(period_a), 50);
    check_value("lit_div50_high", 32'(high_a), 25);

    // Single edge then silence: the rise is acted on at edge c+2, the stall 63 edges later.
    @(negedge clock_in);
    c = cyc;
    sig_a = 1;
    repeat (2) @(negedge clock_in);
    sig_a = 0;
    while (cyc < c + 65) @(negedge clock_in);
    check_value("lit_stall_early", 32'(stalled_a), 0);
    @(negedge clock_in);
    check_value("lit_stall_set", 32'(stalled_a), 1);
    check_value("lit_stall_novalid", 32'(valid_a), 0);

    apply_stimulus(0, 4, 2, 4);
    check_value("lit_resume_stalled", 32'(stalled_a), 0);
    check_value("lit_resume_period", 32'(period_a), 4);

    @(negedge clock_in);
    reset_a = 1;
    @(negedge clock_in);
    reset_a = 0;
    fork
      apply_stimulus(0, 4, 2, 12);
      begin
        for (int n = 0; n < 100; n++) begin
          @(negedge clock_in);
          if (e_valid[0]) break;
        end
        check_value("wait_first_valid_a", 32'(valid_a), 1);
        ready_a = 0;
        repeat (12) @(negedge clock_in);
        check_value("lit_frozen_period", 32'(period_a), 4);
        check_value("lit_frozen_high", 32'(high_a), 2);
        check_value("lit_frozen_valid", 32'(valid_a), 1);
        check_value("lit_overrun_set", 32'(overrun_a), 1);
        ready_a = 1;
      end
    join
    check_value("lit_overrun_sticky", 32'(overrun_a), 1);
    check_value("lit_after_overrun_period", 32'(period_a), 4);

    apply_stimulus(1, 20, 10, 4);
    check_value("lit_b_stalled", 32'(stalled_b), 1);
    check_value("lit_b_novalid", 32'(valid_b), 0);
    check_value("lit_b_noresult", 32'(period_b), 0);

    apply_stimulus(1, 6, 3, 5);
    check_value("lit_b_div6_period", 32'(period_b), 6);
    check_value("lit_b_div6_high", 32'(high_b), 3);
    check_value("lit_b_div6_stalled", 32'(stalled_b), 0);

    fork
      apply_stimulus(1, 6, 3, 4);
      begin
        repeat (8) @(negedge clock_in);
        reset_b = 1;
        @(negedge clock_in);
        reset_b = 0;
        check_value("lit_midreset_valid", 32'(valid_b), 0);
        check_value("lit_midreset_period", 32'(period_b), 0);
        check_value("lit_midreset_high", 32'(high_b), 0);
        check_value("lit_midreset_stalled", 32'(stalled_b), 0);
      end
    join
    apply_stimulus(1, 6, 3, 3);
    check_value("lit_postreset_period", 32'(period_b), 6);

    repeat (3) @(negedge clock_in);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_period_meter.md
CLK_PERIOD_METER -- requirements
Module: clk_period_meter

Interface
REQ-001 Parameter CNT_W, default 28: width of all cycle counters and result fields.
REQ-002 Parameter TIMEOUT, default 28'd100_000_000: clock_in cycles without a rising edge before a stall is declared; legal range 2..2^CNT_W-1.
REQ-003 clock_in  input  1  system clock; all logic is clocked on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sig_in  input  1  divided clock under measurement; asynchronous to clock_in.
REQ-006 meas_ready  input  1  consumer accepts the current result.
REQ-007 meas_valid  output  1  period_cnt and high_cnt hold a result.
REQ-008 period_cnt  output  CNT_W  clock_in cycles between successive sig_in rising edges.
REQ-009 high_cnt  output  CNT_W  clock_in cycles in that period with sig_in high.
REQ-010 sat  output  1  result saturated; the count reached all-ones.
REQ-011 stalled  output  1  no sig_in rising edge for TIMEOUT cycles.
REQ-012 overrun  output  1  sticky; at least one result was dropped.

Function
REQ-013 sig_in SHALL pass through a 2-flop synchronizer; all detection SHALL use the second flop (s_sync) and its one-cycle delayed copy (s_prev).
REQ-014 A rising edge (rise) SHALL be s_sync=1 and s_prev=0; latency from a sig_in transition to rise is 2-3 clock_in cycles.
REQ-015 FSM states SHALL be WAIT_EDGE and MEASURE; reset enters WAIT_EDGE.
REQ-016 WAIT_EDGE with rise: enter MEASURE, set running counters per_run=1 and hi_run=s_sync, produce no result.
REQ-017 In MEASURE without rise: per_run and hi_run (hi_run only when s_sync=1) SHALL increment and saturate at all-ones.
REQ-018 In MEASURE with rise: form result period=per_run and high=hi_run, then restart per_run=1 and hi_run=1.
REQ-019 The result sat flag SHALL be set when per_run was all-ones at capture.
REQ-020 In MEASURE without rise, per_run reaching TIMEOUT SHALL set stalled=1 and return the FSM to WAIT_EDGE; no result is produced.
REQ-021 stalled SHALL clear when the next result is formed.
REQ-022 Result handshake: a transfer occurs when meas_valid=1 and meas_ready=1.
REQ-023 Outputs SHALL remain stable while meas_valid=1 and no transfer occurs.
REQ-024 A formed result SHALL load the output registers and set meas_valid=1 the next cycle when meas_valid=0 or a transfer occurs in the same cycle.
REQ-025 A formed result SHALL otherwise be discarded and overrun set to 1.
REQ-026 A transfer with no new result SHALL clear meas_valid.
REQ-027 The meas_ready value SHALL be ignored while meas_valid=0.
REQ-028 Counter arithmetic is CNT_W-bit unsigned; no wrap-around is permitted, and saturation is the only overflow behaviour.

Reset
REQ-029 reset=1 SHALL set meas_valid=0, period_cnt=0, high_cnt=0, sat=0, stalled=0, overrun=0, synchronizer flops=0, counters=0 and FSM=WAIT_EDGE, all in the next cycle.
REQ-030 Reset asserted mid-measurement SHALL abandon that measurement; the first rise after reset only arms the block (REQ-016).
REQ-031 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-032 Bench: sig_in from a divide-by-4 generator on clock_in, meas_ready=1 -> first meas_valid after the second detected rise; then period_cnt=4, high_cnt=2, sat=0 every 4 cycles.
REQ-033 Bench: divide-by-7 generator -> period_cnt=7, high_cnt=3; then divide-by-50 -> period_cnt=50, high_cnt=25.
REQ-034 Bench: TIMEOUT=64, sig_in held low after an edge -> stalled=1 exactly 63 cycles after that rise is detected, no meas_valid; resume toggling -> first rise arms, second produces a result and clears stalled.
REQ-035 Bench: divide-by-4, meas_ready=0 for 12 cycles after the first meas_valid -> outputs frozen at the first result, overrun=1; meas_ready=1 -> results resume and overrun stays 1.
REQ-036 Bench: CNT_W=4, TIMEOUT=15, sig_in period 20 -> no result and stalled=1; separately, reset pulse mid-period -> all outputs 0 next cycle, and the first subsequent result needs two rises.
